// File: rtl/multisim_pull_unpacker.sv
// multisim_pull_unpacker
// Buffers full-width words from the multisim pull client in a small FIFO and
// serializes each word into RATIO narrow beats, least-significant slice first,
// on a valid/ready stream with a last-beat marker.
module multisim_pull_unpacker #(
  parameter int OUT_WIDTH  = 16,
  parameter int RATIO      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_vld,
  output logic                              in_rdy,
  input  logic [OUT_WIDTH*RATIO-1:0]        in_data,
  output logic                              out_vld,
  input  logic                              out_rdy,
  output logic [OUT_WIDTH-1:0]              out_data,
  output logic                              out_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic [31:0]                       word_count
);

  localparam int IN_W  = OUT_WIDTH * RATIO;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Storage and control state
  logic [IN_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [IN_W-1:0]  r_shift;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_word_count;
  state_t           r_state;

  // Combinational control
  state_t w_state_nxt;
  logic   w_push;
  logic   w_pop;
  logic   w_shift;
  logic   w_word_done;
  logic   w_fire;
  logic   w_fifo_nonempty;

  // in_rdy depends only on registered occupancy (and reset), never on out_rdy,
  // so a pop in the same cycle cannot open a slot for a push.
  assign in_rdy          = !rst && (r_count != DEPTH_C);
  assign w_push          = in_vld && in_rdy;
  assign w_fifo_nonempty = (r_count != '0);

  assign out_vld    = (r_state == SHIFT);
  assign out_data   = r_shift[OUT_WIDTH-1:0];
  assign out_last   = (r_state == SHIFT) && (r_idx == LAST_IDX);
  assign fifo_count = r_count;
  assign word_count = r_word_count;

  assign w_fire = out_vld && out_rdy;

  // Next-state logic: decides when to pop the FIFO head into the shift register
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    w_word_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_fire) begin
          if (r_idx == LAST_IDX) begin
            w_word_done = 1'b1;
            // Reload straight from the FIFO to keep beats back-to-back.
            if (w_fifo_nonempty) begin
              w_pop = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO word storage; only written on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Shift register and beat index: load on pop, shift on a non-final accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_idx   <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rptr];
      r_idx   <= '0;
    end else if (w_shift) begin
      r_shift <= r_shift >> OUT_WIDTH;
      r_idx   <= r_idx + 1'b1;
    end
  end

  // Completed-word counter, wraps at 32 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_count <= '0;
    end else if (w_word_done) begin
      r_word_count <= r_word_count + 32'd1;
    end
  end

endmodule

// File: doc/multisim_pull_unpacker.md
Name: multisim_pull_unpacker

Overview:
- Sits directly downstream of the multisim pull client and consumes its `data_vld`/`data`/`data_rdy` stream.
- Buffers full-width pulled words in a small FIFO. Serializes each word into RATIO narrower beats, LSB slice first, on a valid/ready output stream with a last-beat marker.
- Lets simulator-side wide DPI transfers drive narrow RTL interfaces without stalling the pull loop.

Parameters:
- OUT_WIDTH, 16, width of one output beat.
- RATIO, 4, beats per input word (>=1); input width is OUT_WIDTH*RATIO.
- FIFO_DEPTH, 4, input word FIFO depth (power of two, >=2).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- in_vld  input  1  input word valid (from pull client data_vld).
- in_rdy  output  1  input ready (to pull client data_rdy).
- in_data  input  OUT_WIDTH*RATIO  input word.
- out_vld  output  1  output beat valid.
- out_rdy  input  1  output beat ready.
- out_data  output  OUT_WIDTH  output beat.
- out_last  output  1  high on final beat of a word.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently stored in FIFO (excludes word in shift register).
- word_count  output  32  count of fully emitted words.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_vld=0, out_last=0, out_data=0, fifo_count=0, word_count=0, FIFO pointers=0, beat index=0, state=IDLE. in_rdy=0 while rst is high.
- Reset mid-operation drops any partial word and all FIFO contents. The next word after reset starts at beat 0.
- in_rdy is a function of registered state only: rst==0 && fifo_count<FIFO_DEPTH. It has no combinational path from out_rdy.
- Push on in_vld&&in_rdy: write in_data at write pointer, then increment it. Pointers wrap modulo FIFO_DEPTH.
- State machine:
  - IDLE: if fifo_count>0, pop the head into the shift register, set beat index=0, go to SHIFT (out_vld=1 from next cycle). Otherwise stay in IDLE.
  - SHIFT: out_vld=1, out_data=shift_reg[OUT_WIDTH-1:0], out_last=(index==RATIO-1).
  - SHIFT on out_vld&&out_rdy with index<RATIO-1: shift right by OUT_WIDTH, index++.
  - SHIFT on out_vld&&out_rdy with index==RATIO-1: word_count++. If fifo_count>0, pop the next word in the same cycle (no bubble) and set index=0. Otherwise go to IDLE (out_vld=0 next cycle).
- Stall: while out_vld&&!out_rdy, out_data, out_last and index hold stable.
- Latency: a word accepted at edge N into an empty block with IDLE state gives out_vld=1 after edge N+1.
- Simultaneous push and pop: fifo_count stays unchanged and both pointers advance.
- Full: no push occurs even if a pop happens the same cycle, because in_rdy was already 0. in_rdy reasserts the cycle after the pop.
- Empty pop is impossible: a word pushed at edge N is poppable no earlier than edge N+1.
- RATIO==1: out_last is constantly 1 whenever out_vld=1, and every handshake completes a word.
- word_count wraps 0xFFFF_FFFF -> 0.

Test Plan:
1. OUT_WIDTH=16, RATIO=4. Push 0x4444_3333_2222_1111 with out_rdy=1 -> beats 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, out_last only on 0x4444, out_vld first high one cycle after the input handshake, word_count=1.
2. Back-to-back: push 4 words continuously with out_rdy=1 -> 16 consecutive valid beats with no bubble, out_last every 4th beat, word_count=4.
3. Backpressure: out_rdy=0, in_vld=1 continuously -> exactly 5 words accepted (1 in shift register, 4 in FIFO), then in_rdy=0 and fifo_count=4. out_data holds 0x1111 stably. Releasing out_rdy reasserts in_rdy after the first word completes.
4. Mid-word stall: toggle out_rdy 1,0,0,1,1,0,1 -> out_data/out_last change only after accepted beats, beat order is intact, word_count increments once per 4 accepted beats.
5. Reset after 2 beats of a word with 2 words queued -> next cycle out_vld=0, fifo_count=0, word_count=0, in_rdy=0 during rst. A new word afterwards emits from beat 0.
6. Pointer wrap: push 10 distinct words with random out_rdy -> all 40 beats emerge in order, word_count=10, fifo_count never exceeds 4.
